sar_search: RTL and testbench
=============================

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin search; sampled only in IDLE.
REQ-005 SHALL have port: trial  output  WIDTH  candidate operand presented to external comparator.
REQ-006 SHALL have port: cmp_req  output  1  comparison request; trial stable while high.
REQ-007 SHALL have port: cmp_ack  input  1  comparator response valid; meaningful only while cmp_req high.
REQ-008 SHALL have port: cmp_ge  input  1  target >= trial, valid with cmp_ack.
REQ-009 SHALL have port: cmp_eq  input  1  target == trial, valid with cmp_ack.
REQ-010 SHALL have port: busy  output  1  high in REQ and DONE states.
REQ-011 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port: result  output  WIDTH  search outcome, held until next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE.
REQ-014 IDLE: start=1 at edge k -> state REQ, bit index = WIDTH-1, accumulator = 0, trial = 1<<(WIDTH-1).
REQ-015 REQ: cmp_req SHALL be 1; trial, index and accumulator SHALL hold every cycle cmp_ack=0 (unbounded wait).
REQ-016 REQ with cmp_ack=1: accumulator bit[index] SHALL be set to cmp_ge; other bits unchanged.
REQ-017 Same edge, if index > 0: index decrements, trial = updated accumulator | (1 << new index), stay REQ; cmp_req stays high (back-to-back requests allowed).
REQ-018 Same edge, if index == 0: result = updated accumulator, state DONE, cmp_req drops.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Zero-wait latency: start at edge k -> cmp_req high in cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1.
REQ-021 start while busy=1 SHALL be ignored; start during DONE cycle ignored (re-sampled in IDLE).
REQ-022 cmp_ack, cmp_ge and cmp_eq outside REQ SHALL be ignored.
REQ-023 trial in IDLE/DONE SHALL hold its last value; only valid while cmp_req=1.
REQ-024 No arithmetic overflow: all operations are bitwise within WIDTH.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, trial=0, cmp_req=0, busy=0, done=0, result=0, index/accumulator=0.
REQ-026 Reset mid-search SHALL abort without a done pulse; first start after rst_n rises starts a fresh search.

Configuration
REQ-027 Macro SAR_SEARCH_EQ_EARLY_EN SHALL control early termination.
REQ-028 Defined: REQ with cmp_ack=1 and cmp_eq=1 -> result = current trial, state DONE regardless of index (cmp_eq takes precedence over REQ-016/017).
REQ-029 Not defined: cmp_eq port present but ignored; always WIDTH comparisons.

Verification
REQ-030 WIDTH=4, target 11, zero-wait comparator -> trials 8,12,10,11; result=11; done in cycle k+5.
REQ-031 Target 0 -> trials 8,4,2,1, result=0; target 15 -> trials 8,12,14,15, result=15.
REQ-032 Target 6, cmp_ack delayed 3 cycles per request -> trial stable during waits; trials 8,4,6,7; result=6; done at cycle k+17.
REQ-033 Target 11, start pulsed again during REQ, rst_n pulsed low after second comparison -> extra start ignored; all outputs 0 immediately, no done; new start yields result 11.
REQ-034 Target 8, macro defined -> single comparison (trial 8), result=8, done at cycle k+2; macro undefined -> four comparisons, result=8, done at k+5.

Source files
------------

// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
// Successive-approximation search controller. Walks a WIDTH-bit candidate
// from MSB to LSB, asking an external comparator on each step whether the
// target is >= the candidate, and builds the result one bit per answer.
//
// Parameters
//   WIDTH    operand/result width in bits (>= 2)
//
// Ports
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    begin a search (sampled only in IDLE)
//   trial    candidate presented to the comparator (valid while cmp_req)
//   cmp_req  comparison request; trial held stable while high
//   cmp_ack  comparator answer valid (only looked at in REQ)
//   cmp_ge   target >= trial, valid with cmp_ack
//   cmp_eq   target == trial, valid with cmp_ack
//   busy     high in REQ and DONE
//   done     one-cycle pulse, result valid
//   result   search outcome, held until overwritten by the next search
//
// Build option
//   SAR_SEARCH_EQ_EARLY_EN  when defined, an acknowledged cmp_eq ends the
//                           search at once with result = current trial.
//                           When undefined cmp_eq is ignored and every
//                           search makes exactly WIDTH comparisons.
// ---------------------------------------------------------------------------
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for start; trial/result hold their last values
// REQ    | cmp_req high, waiting for cmp_ack on the current bit index
// DONE   | single-cycle done pulse, then back to IDLE unconditionally
// ---------------------------------------------------------------------------
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] trial,
   output logic             cmp_req,
   input  logic             cmp_ack,
   input  logic             cmp_ge,
   input  logic             cmp_eq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LSB_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       state_q,  state_d;
   logic [IW-1:0]    idx_q,    idx_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] trial_q,  trial_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0] acc_upd;
   logic [IW-1:0]    idx_dec;
   logic             eq_hit;

`ifdef SAR_SEARCH_EQ_EARLY_EN
   assign eq_hit = cmp_eq;
`else
   logic unused_cmp_eq;
   assign unused_cmp_eq = cmp_eq;
   assign eq_hit        = 1'b0;
`endif

   assign idx_dec = idx_q - 1'b1;

   always_comb begin
      acc_upd          = acc_q;
      acc_upd[idx_q]   = cmp_ge;

      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      trial_d  = trial_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
               idx_d   = IW'(WIDTH - 1);
               acc_d   = '0;
               trial_d = MSB_ONLY;
            end
         end

         S_REQ: begin
            if (cmp_ack) begin
               if (eq_hit) begin
                  // exact match: the current candidate is the answer
                  result_d = trial_q;
                  state_d  = S_DONE;
               end else begin
                  acc_d = acc_upd;
                  if (idx_q != '0) begin
                     // next candidate = bits decided so far plus the next bit set
                     idx_d   = idx_dec;
                     trial_d = acc_upd | (LSB_ONE << idx_dec);
                  end else begin
                     result_d = acc_upd;
                     state_d  = S_DONE;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         trial_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         trial_q  <= trial_d;
         result_q <= result_d;
      end
   end

   assign trial   = trial_q;
   assign result  = result_q;
   assign cmp_req = (state_q == S_REQ);
   assign done    = (state_q == S_DONE);
   assign busy    = (state_q == S_REQ) || (state_q == S_DONE);

endmodule

// File: tb/tb_sar_search.sv
// ---------------------------------------------------------------------------
// tb_sar_search
// Directed bench for sar_search (WIDTH=4). A behavioural comparator inside
// the search task answers each request after a chosen number of wait cycles;
// the sequence of presented trials, done timing and result are checked
// against hand-derived values. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_sar_search;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] trial;
   logic       cmp_req;
   logic       cmp_ack;
   logic       cmp_ge;
   logic       cmp_eq;
   logic       busy;
   logic       done;
   logic [3:0] result;

   int checks = 0;
   int errors = 0;

   logic [3:0] tr_log [0:15];
   int         tr_n;
   int         done_cyc;
   logic [3:0] res_at_done;

   sar_search #(.WIDTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .trial   (trial),
      .cmp_req (cmp_req),
      .cmp_ack (cmp_ack),
      .cmp_ge  (cmp_ge),
      .cmp_eq  (cmp_eq),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one search. Cycle 1 is the cycle right after the edge that samples
   // start; done_cyc is the cycle in which done is seen high (-1 if never).
   task automatic search(input logic [3:0] tgt, input int dly);
      int         waits;
      int         cyc;
      logic       new_req;
      logic [3:0] held;
      tr_n     = 0;
      done_cyc = -1;
      waits    = 0;
      new_req  = 1'b1;
      held     = '0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            done_cyc    = cyc;
            res_at_done = result;
            break;
         end
         if (cmp_req) begin
            if (new_req) begin
               if (tr_n < 16) tr_log[tr_n] = trial;
               tr_n++;
               held    = trial;
               new_req = 1'b0;
               waits   = 0;
            end else begin
               chk("trial_stable", trial, held);
            end
            if (waits == dly) begin
               cmp_ack = 1'b1;
               cmp_ge  = (tgt >= trial);
               cmp_eq  = (tgt == trial);
               new_req = 1'b1;
            end else begin
               // junk answer bits without ack must have no effect
               cmp_ack = 1'b0;
               cmp_ge  = 1'($urandom_range(1));
               cmp_eq  = 1'($urandom_range(1));
               waits++;
            end
         end else begin
            cmp_ack = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      cmp_ack = 1'b0;
      cmp_ge  = 1'b0;
      cmp_eq  = 1'b0;
      if (done_cyc >= 0) begin
         @(negedge clk);
         chk("done_one_cycle", done, 1'b0);
         chk("idle_after_done", busy, 1'b0);
      end
   endtask

   task automatic check_trials(input string tag, input int n, input logic [15:0] e);
      logic [3:0] ev;
      chk({tag, "_count"}, tr_n, n);
      for (int i = 0; i < n && i < tr_n; i++) begin
         ev = e[15-4*i -: 4];
         chk({tag, "_trial"}, tr_log[i], ev);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      cmp_ack = 1'b0;
      cmp_ge  = 1'b0;
      cmp_eq  = 1'b0;
      #1;
      chk("rst_trial",   trial,   4'd0);
      chk("rst_cmp_req", cmp_req, 1'b0);
      chk("rst_busy",    busy,    1'b0);
      chk("rst_done",    done,    1'b0);
      chk("rst_result",  result,  4'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // comparator activity in IDLE must be ignored
      cmp_ack = 1'b1;
      cmp_ge  = 1'b1;
      cmp_eq  = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ack_busy",   busy,    1'b0);
      chk("idle_ack_req",    cmp_req, 1'b0);
      chk("idle_ack_result", result,  4'd0);
      cmp_ack = 1'b0;
      cmp_ge  = 1'b0;
      cmp_eq  = 1'b0;

      // target 11, zero wait
      search(4'd11, 0);
      check_trials("t11", 4, 16'h8CAB);
      chk("t11_done_cyc", done_cyc, 5);
      chk("t11_result", res_at_done, 4'd11);

      // target 0
      search(4'd0, 0);
      check_trials("t0", 4, 16'h8421);
      chk("t0_done_cyc", done_cyc, 5);
      chk("t0_result", res_at_done, 4'd0);

      // target 15
      search(4'd15, 0);
      check_trials("t15", 4, 16'h8CEF);
      chk("t15_done_cyc", done_cyc, 5);
      chk("t15_result", res_at_done, 4'd15);

      // target 6, ack after 3 wait cycles per request
      search(4'd6, 3);
`ifdef SAR_SEARCH_EQ_EARLY_EN
      check_trials("t6w", 3, 16'h8460);
      chk("t6w_done_cyc", done_cyc, 13);
`else
      check_trials("t6w", 4, 16'h8467);
      chk("t6w_done_cyc", done_cyc, 17);
`endif
      chk("t6w_result", res_at_done, 4'd6);
      chk("t6w_result_held", result, 4'd6);

      // target 11, extra start during REQ, reset after second comparison
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rs_first_trial", trial, 4'd8);
      start   = 1'b1;
      cmp_ack = 1'b1;
      cmp_ge  = 1'b1;
      cmp_eq  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("rs_extra_start_ignored", trial, 4'd12);
      cmp_ack = 1'b1;
      cmp_ge  = 1'b0;
      cmp_eq  = 1'b0;
      @(posedge clk);
      #2;
      chk("rs_trial_before_rst", trial, 4'd10);
      chk("rs_req_before_rst", cmp_req, 1'b1);
      rst_n   = 1'b0;
      cmp_ack = 1'b0;
      #1;
      chk("rs_trial",   trial,   4'd0);
      chk("rs_cmp_req", cmp_req, 1'b0);
      chk("rs_busy",    busy,    1'b0);
      chk("rs_done",    done,    1'b0);
      chk("rs_result",  result,  4'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rs_no_done", done, 1'b0);
      end
      rst_n = 1'b1;
      search(4'd11, 0);
      check_trials("rs_t11", 4, 16'h8CAB);
      chk("rs_t11_done_cyc", done_cyc, 5);
      chk("rs_t11_result", res_at_done, 4'd11);

      // target 8
      search(4'd8, 0);
`ifdef SAR_SEARCH_EQ_EARLY_EN
      check_trials("t8", 1, 16'h8000);
      chk("t8_done_cyc", done_cyc, 2);
`else
      check_trials("t8", 4, 16'h8CA9);
      chk("t8_done_cyc", done_cyc, 5);
`endif
      chk("t8_result", res_at_done, 4'd8);
      repeat (3) @(negedge clk);
      chk("t8_result_held", result, 4'd8);
      chk("t8_idle_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
